// File: rtl/mul_operand_sequencer.sv
// Operand/result sequencer around a combinational array multiplier: it holds the operands
// for a fixed settle budget, then captures the product and hands it downstream.
module mul_operand_sequencer #(
   parameter int unsigned OPER_LENGTH   = 3,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CNT_WIDTH     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [OPER_LENGTH-1:0]   in_x,
   input  logic [OPER_LENGTH-1:0]   in_y,
   output logic [OPER_LENGTH-1:0]   mul_x,
   output logic [OPER_LENGTH-1:0]   mul_y,
   input  logic [2*OPER_LENGTH-1:0] mul_result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*OPER_LENGTH-1:0] out_result,
   output logic                     busy,
   output logic [CNT_WIDTH-1:0]     ops_done
);

   localparam int unsigned PROD_W = 2 * OPER_LENGTH;
   localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [SET_W-1:0]       cnt_q, cnt_d;
   logic [OPER_LENGTH-1:0] mul_x_q, mul_x_d;
   logic [OPER_LENGTH-1:0] mul_y_q, mul_y_d;
   logic [PROD_W-1:0]      out_result_q, out_result_d;
   logic                   out_valid_q, out_valid_d;
   logic                   busy_q, busy_d;
   logic [CNT_WIDTH-1:0]   ops_done_q, ops_done_d;
   logic                   accept;

   // out_ready -> in_ready is the only combinational path, so DONE can hand straight back to SETTLE
   assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mul_x_d      = mul_x_q;
      mul_y_d      = mul_y_q;
      out_result_d = out_result_q;
      out_valid_d  = out_valid_q;
      ops_done_d   = ops_done_q;

      case (state_q)
         IDLE: begin
            out_valid_d = 1'b0;
            if (accept) begin
               mul_x_d = in_x;
               mul_y_d = in_y;
               cnt_d   = SET_LOAD;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - SET_W'(1);
            end else begin
               out_result_d = mul_result;
               out_valid_d  = 1'b1;
               state_d      = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               ops_done_d  = ops_done_q + CNT_WIDTH'(1);
               out_valid_d = 1'b0;
               if (accept) begin
                  mul_x_d = in_x;
                  mul_y_d = in_y;
                  cnt_d   = SET_LOAD;
                  state_d = SETTLE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase

      busy_d = (state_d == SETTLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         mul_x_q      <= '0;
         mul_y_q      <= '0;
         out_result_q <= '0;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         ops_done_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mul_x_q      <= mul_x_d;
         mul_y_q      <= mul_y_d;
         out_result_q <= out_result_d;
         out_valid_q  <= out_valid_d;
         busy_q       <= busy_d;
         ops_done_q   <= ops_done_d;
      end
   end

   assign mul_x      = mul_x_q;
   assign mul_y      = mul_y_q;
   assign out_result = out_result_q;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;
   assign ops_done   = ops_done_q;

endmodule
